uart_tx_serializer: RTL and testbench

//  Downstream of the AXI UART write slave: takes accepted write-data bytes and

---
 rtl/uart_pkg.sv | 16 +
 rtl/uart_tx_fifo.sv | 62 ++++++
 rtl/uart_tx_serializer.sv | 164 ++++++++++++++++
 tb/tb_uart_tx_serializer.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: TX FSM state encoding and frame constants.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_state_e;

    localparam logic        UART_IDLE_LEVEL = 1'b1;
    localparam int unsigned UART_DATA_BITS  = 8;
    localparam int unsigned UART_BIT_CNT_W  = $clog2(UART_DATA_BITS);

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous byte FIFO for the UART transmitter; a level counter separates
// full from empty so the pointers can wrap freely.
module uart_tx_fifo #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned WIDTH = 8
) (
    input  logic                     i_clock,
    input  logic                     i_reset,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic [WIDTH-1:0]         wdata_i,
    output logic [WIDTH-1:0]         rdata_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   level_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (level_q == LVL_W'(DEPTH));
    assign empty_o = (level_q == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign rdata_o = mem_q[rd_ptr_q];
    assign level_o = level_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        if (do_push && !do_pop) level_d = level_q + LVL_W'(1);
        if (do_pop && !do_push) level_d = level_q - LVL_W'(1);
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage needs no reset: the level counter gates every read.
    always_ff @(posedge i_clock) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/uart_tx_serializer.sv
// 8N1 UART transmitter with an internal byte FIFO, LSB first.
// Define UART_TX_PARITY_EN to insert an even-parity bit between DATA and STOP.
module uart_tx_serializer
    import uart_pkg::*;
#(
    parameter int unsigned CLK_DIV    = 16,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic                          i_clock,
    input  logic                          i_reset,
    input  logic [7:0]                    i_tx_data,
    input  logic                          i_tx_valid,
    output logic                          o_tx_ready,
    output logic                          o_txd,
    output logic                          o_busy,
    output logic [$clog2(FIFO_DEPTH):0]   o_fifo_level
);

    localparam int unsigned BAUD_W = $clog2(CLK_DIV);
    localparam int unsigned BIT_W  = UART_BIT_CNT_W;

    uart_state_e                state_q, state_d;
    logic [BAUD_W-1:0]          baud_q, baud_d;
    logic [BIT_W-1:0]           bit_q, bit_d;
    logic [UART_DATA_BITS-1:0]  shift_q, shift_d;
    logic                       txd_q, txd_d;
`ifdef UART_TX_PARITY_EN
    logic                       parity_q, parity_d;
`endif

    logic                       fifo_pop;
    logic                       fifo_full;
    logic                       fifo_empty;
    logic [UART_DATA_BITS-1:0]  fifo_rdata;
    logic                       baud_end;

    uart_tx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (UART_DATA_BITS)
    ) u_fifo (
        .i_clock (i_clock),
        .i_reset (i_reset),
        .push_i  (i_tx_valid),
        .pop_i   (fifo_pop),
        .wdata_i (i_tx_data),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .level_o (o_fifo_level)
    );

    assign baud_end   = (baud_q == BAUD_W'(CLK_DIV - 1));
    assign o_tx_ready = !fifo_full;
    assign o_txd      = txd_q;
    assign o_busy     = (state_q != ST_IDLE) || !fifo_empty;

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_q  <= ST_IDLE;
            baud_q   <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            txd_q    <= UART_IDLE_LEVEL;
`ifdef UART_TX_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            baud_q   <= baud_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            txd_q    <= txd_d;
`ifdef UART_TX_PARITY_EN
            parity_q <= parity_d;
`endif
        end
    end

    always_comb begin
        state_d  = state_q;
        baud_d   = baud_q + BAUD_W'(1);
        bit_d    = bit_q;
        shift_d  = shift_q;
        fifo_pop = 1'b0;
`ifdef UART_TX_PARITY_EN
        parity_d = parity_q;
`endif

        case (state_q)
            ST_IDLE: begin
                baud_d = '0;
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    shift_d  = fifo_rdata;
`ifdef UART_TX_PARITY_EN
                    parity_d = ^fifo_rdata;
`endif
                    state_d  = ST_START;
                end
            end
            ST_START: begin
                if (baud_end) begin
                    baud_d  = '0;
                    bit_d   = '0;
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (baud_end) begin
                    baud_d = '0;
                    if (bit_q == BIT_W'(UART_DATA_BITS - 1)) begin
`ifdef UART_TX_PARITY_EN
                        state_d = ST_PARITY;
`else
                        state_d = ST_STOP;
`endif
                    end else begin
                        bit_d   = bit_q + BIT_W'(1);
                        shift_d = shift_q >> 1;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
                if (baud_end) begin
                    baud_d  = '0;
                    state_d = ST_STOP;
                end
            end
`endif
            ST_STOP: begin
                if (baud_end) begin
                    baud_d = '0;
                    // Back-to-back frames: reload straight into START with no idle gap.
                    if (!fifo_empty) begin
                        fifo_pop = 1'b1;
                        shift_d  = fifo_rdata;
`ifdef UART_TX_PARITY_EN
                        parity_d = ^fifo_rdata;
`endif
                        state_d  = ST_START;
                    end else begin
                        state_d  = ST_IDLE;
                    end
                end
            end
            default: begin
                baud_d  = '0;
                state_d = ST_IDLE;
            end
        endcase

        // The line register follows the state being entered, so o_txd changes on the transition edge.
        case (state_d)
            ST_START:  txd_d = 1'b0;
            ST_DATA:   txd_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
            ST_PARITY: txd_d = parity_d;
`endif
            default:   txd_d = UART_IDLE_LEVEL;
        endcase
    end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Scoreboard bench for uart_tx_serializer: a line receiver pops expected bytes,
// directed tasks check frame timing, FIFO full/push-pop behaviour and reset abort.
module tb_uart_tx_serializer;

    localparam int unsigned CLK_DIV    = 4;
    localparam int unsigned FIFO_DEPTH = 8;
`ifdef UART_TX_PARITY_EN
    localparam int FRAME = 11 * CLK_DIV;
`else
    localparam int FRAME = 10 * CLK_DIV;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready;
    logic       txd;
    logic       busy;
    logic [3:0] level;

    int         n_vec = 0;
    int         n_fail = 0;
    logic [7:0] exp_q [$];
    logic       aborted;
    logic [FRAME-1:0] last_line;

    uart_tx_serializer #(
        .CLK_DIV    (CLK_DIV),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .i_clock      (clk),
        .i_reset      (rst),
        .i_tx_data    (tx_data),
        .i_tx_valid   (tx_valid),
        .o_tx_ready   (tx_ready),
        .o_txd        (txd),
        .o_busy       (busy),
        .o_fifo_level (level)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected line level at cycle c of a frame carrying byte b.
    function automatic logic exp_line(input logic [7:0] b, input int c);
        int bt;
        bt = c / int'(CLK_DIV);
        if (bt == 0) return 1'b0;
        if (bt <= 8) return b[bt-1];
`ifdef UART_TX_PARITY_EN
        if (bt == 9) return ^b;
`endif
        return 1'b1;
    endfunction

    task automatic mwait(input int n);
        repeat (n) begin
            @(negedge clk);
            if (rst) aborted = 1'b1;
        end
    endtask

    // Receiver/monitor: samples each bit at its centre and checks against the scoreboard.
    initial begin : monitor
        logic [7:0] got;
        logic       stopb;
        logic [7:0] expb;
`ifdef UART_TX_PARITY_EN
        logic       parb;
`endif
        forever begin
            @(negedge clk);
            if (!rst && txd === 1'b0) begin
                aborted = 1'b0;
                mwait(2);
                if (!aborted) check("rx_start_bit", 32'(txd), 32'd0);
                for (int i = 0; i < 8; i++) begin
                    mwait(4);
                    got[i] = txd;
                end
`ifdef UART_TX_PARITY_EN
                mwait(4);
                parb = txd;
`endif
                mwait(4);
                stopb = txd;
                if (!aborted) begin
                    check("rx_stop_bit", 32'(stopb), 32'd1);
                    if (exp_q.size() == 0) begin
                        check("rx_unexpected_byte", 32'(got), 32'h100);
                    end else begin
                        expb = exp_q.pop_front();
                        check("rx_byte", 32'(got), 32'(expb));
`ifdef UART_TX_PARITY_EN
                        check("rx_parity", 32'(parb), 32'(^expb));
`endif
                    end
                end
            end
        end
    end

    // Push n bytes on consecutive edges into an idle DUT and check the line cycle by cycle.
    task automatic send_burst(input logic [23:0] bytes, input int n, input string tag);
        int errs;
        int busy_lo;
        logic [7:0] bk;
        @(negedge clk);
        check({tag, "_ready"}, 32'(tx_ready), 32'd1);
        for (int k = 0; k < n; k++) exp_q.push_back(bytes[8*k +: 8]);
        tx_valid = 1'b1;
        tx_data  = bytes[7:0];
        @(negedge clk);
        check({tag, "_level_after_push"}, 32'(level), 32'd1);
        check({tag, "_txd_before_start"}, 32'(txd), 32'd1);
        if (n > 1) tx_data = bytes[15:8];
        else tx_valid = 1'b0;
        errs = 0;
        busy_lo = 0;
        for (int i = 0; i < n * FRAME; i++) begin
            @(negedge clk);
            if (i + 2 < n) tx_data = bytes[8*(i+2) +: 8];
            else tx_valid = 1'b0;
            bk = bytes[8*(i/FRAME) +: 8];
            if (txd !== exp_line(bk, i % FRAME)) errs++;
            if (busy !== 1'b1) busy_lo++;
            if (i < FRAME) last_line[i] = txd;
        end
        check({tag, "_line_errors"}, 32'(errs), 32'd0);
        check({tag, "_busy_gaps"}, 32'(busy_lo), 32'd0);
        @(negedge clk);
        check({tag, "_busy_after"}, 32'(busy), 32'd0);
    endtask

    task automatic wait_idle(input int budget, input string tag);
        int i;
        i = 0;
        while (busy !== 1'b0 && i < budget) begin
            @(negedge clk);
            i++;
        end
        check({tag, "_drained"}, 32'(busy === 1'b0), 32'd1);
        repeat (4) @(negedge clk);
        check({tag, "_scoreboard_empty"}, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail + 1);
        $fatal(1);
    end

    initial begin : stim
        int k;
        int guard;
        int max_lvl;
        int bad_ready;
        int saw_full;
        logic rdy;

        repeat (3) @(negedge clk);
        check("reset_txd", 32'(txd), 32'd1);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_level", 32'(level), 32'd0);
        check("reset_ready", 32'(tx_ready), 32'd1);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Single frame and back-to-back frames.
        send_burst(24'h000055, 1, "t1_55");
        send_burst(24'hFF3CA5, 3, "t2_burst");

        // Hold valid for 12 bytes: ready may only drop while the FIFO holds 8.
        k = 0; guard = 0; max_lvl = 0; bad_ready = 0; saw_full = 0;
        while (k < 12 && guard < 2000) begin
            @(negedge clk);
            guard++;
            tx_valid = 1'b1;
            tx_data  = 8'h10 + 8'(k);
            rdy = tx_ready;
            if (int'(level) > max_lvl) max_lvl = int'(level);
            if (!rdy) begin
                saw_full = 1;
                if (level != 4'd8) bad_ready++;
            end
            @(posedge clk);
            if (rdy) begin
                exp_q.push_back(8'h10 + 8'(k));
                k++;
            end
        end
        @(negedge clk);
        tx_valid = 1'b0;
        check("t3_all_accepted", 32'(k), 32'd12);
        check("t3_max_level", 32'(max_lvl), 32'd8);
        check("t3_ready_fell", 32'(saw_full), 32'd1);
        check("t3_ready_vs_level", 32'(bad_ready), 32'd0);
        wait_idle(14 * FRAME, "t3");

        // Fill to 8 behind a running frame, then probe the STOP-end pop edges.
        k = 0; guard = 0;
        while (k < 9 && guard < 200) begin
            @(negedge clk);
            guard++;
            tx_valid = 1'b1;
            tx_data  = 8'h40 + 8'(k);
            rdy = tx_ready;
            @(posedge clk);
            if (rdy) begin
                exp_q.push_back(8'h40 + 8'(k));
                k++;
            end
        end
        @(negedge clk);
        tx_data = 8'h49;
        check("t4_full_level", 32'(level), 32'd8);
        check("t4_full_ready", 32'(tx_ready), 32'd0);
        guard = 0;
        while (level == 4'd8 && guard < FRAME + 10) begin
            @(negedge clk);
            guard++;
        end
        tx_valid = 1'b0;
        check("t4_pop_no_push_level", 32'(level), 32'd7);
        check("t4_ready_after_pop", 32'(tx_ready), 32'd1);
        repeat (FRAME - 1) @(negedge clk);
        check("t4_level_before_pushpop", 32'(level), 32'd7);
        tx_valid = 1'b1;
        tx_data  = 8'h4A;
        exp_q.push_back(8'h4A);
        @(negedge clk);
        tx_valid = 1'b0;
        check("t4_pushpop_level", 32'(level), 32'd7);
        wait_idle(12 * FRAME, "t4");

        // Reset during DATA bit 3 of 0xF7 with two more bytes queued.
        @(negedge clk);
        tx_valid = 1'b1;
        tx_data  = 8'hF7;
        @(negedge clk);
        tx_data  = 8'h11;
        @(negedge clk);
        tx_data  = 8'h22;
        @(negedge clk);
        tx_valid = 1'b0;
        repeat (15) @(negedge clk);
        check("t5_bit3_before_reset", 32'(txd), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("t5_reset_txd", 32'(txd), 32'd1);
        check("t5_reset_level", 32'(level), 32'd0);
        check("t5_reset_busy", 32'(busy), 32'd0);
        check("t5_reset_ready", 32'(tx_ready), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        repeat (2 * FRAME) @(negedge clk);
        check("t5_idle_after_reset", 32'({busy, txd}), 32'b01);
        exp_q.delete();
        send_burst(24'h000096, 1, "t5_after");

        // Parity-sensitive bytes.
        send_burst(24'h000007, 1, "t6_07");
`ifdef UART_TX_PARITY_EN
        check("t6_parity_07", 32'(last_line[9*CLK_DIV+2]), 32'd1);
`endif
        send_burst(24'h000003, 1, "t6_03");
`ifdef UART_TX_PARITY_EN
        check("t6_parity_03", 32'(last_line[9*CLK_DIV+2]), 32'd0);
`endif
        repeat (4) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
